// File: rtl/cpu_pkg.sv
// Shared CPU control definitions: FunSel/RegSel codes, fetch state enum and
// the per-state control decode used by the fetch sequencer.
package cpu_pkg;

    localparam logic [1:0] FS_DEC   = 2'b00;
    localparam logic [1:0] FS_INC   = 2'b01;
    localparam logic [1:0] FS_LOAD  = 2'b10;
    localparam logic [1:0] FS_CLEAR = 2'b11;

    localparam logic [3:0] RS_NONE = 4'b0000;
    localparam logic [3:0] RS_PC   = 4'b1000;

    localparam logic [1:0] PC_SEL = 2'b00;

    typedef enum logic [2:0] {
        F_IDLE,
        F_CLR,
        F_LO_ADDR,
        F_LO_LOAD,
        F_HI_ADDR,
        F_HI_LOAD,
        F_DONE
    } fetch_state_t;

    typedef struct packed {
        logic       busy;
        logic       fetch_done;
        logic       mem_en;
        logic [1:0] outd_sel;
        logic [3:0] reg_sel;
        logic [1:0] arf_fun;
        logic       ir_en;
        logic       ir_lh;
        logic [1:0] ir_fun;
    } fetch_ctrl_t;

    function automatic fetch_ctrl_t fetch_decode(input fetch_state_t s);
        fetch_ctrl_t c;
        c = '0;
        c.busy = (s != F_IDLE);
        case (s)
            F_CLR: begin
                c.ir_en  = 1'b1;
                c.ir_fun = FS_CLEAR;
            end
            F_LO_ADDR, F_HI_ADDR: begin
                c.mem_en   = 1'b1;
                c.outd_sel = PC_SEL;
            end
            F_LO_LOAD, F_HI_LOAD: begin
                c.mem_en   = 1'b1;
                c.outd_sel = PC_SEL;
                c.ir_en    = 1'b1;
                c.ir_lh    = (s == F_HI_LOAD);
                c.ir_fun   = FS_LOAD;
                c.reg_sel  = RS_PC;
                c.arf_fun  = FS_INC;
            end
            F_DONE:  c.fetch_done = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/wait_counter.sv
// 4-bit up-counter for memory wait states: synchronous clear-to-zero,
// count enable and a compare against a fixed terminal count.
module wait_counter #(
    parameter logic [3:0] TC = 4'd0
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic load,
    input  logic en,
    output logic tc
);

    logic [3:0] cnt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            cnt <= 4'd0;
        else if (load)
            cnt <= 4'd0;
        else if (en)
            cnt <= cnt + 4'd1;
    end

    assign tc = (cnt == TC);

endmodule

// File: rtl/instr_fetch_seq.sv
// Byte-serial instruction fetch: reads two bytes at PC into IR (low, then high),
// incrementing PC through the ARF after each byte.
//
// state     | meaning
// ----------+---------------------------------------------
// F_IDLE    | waiting for fetch_req
// F_CLR     | clear IR (CLR_IR=1 only)
// F_LO_ADDR | PC on OutD, memory read, wait states
// F_LO_LOAD | IR low byte load, PC++
// F_HI_ADDR | PC on OutD, memory read, wait states
// F_HI_LOAD | IR high byte load, PC++
// F_DONE    | fetch_done pulse
module instr_fetch_seq
    import cpu_pkg::*;
#(
    parameter int unsigned WAIT_CYC = 0,
    parameter bit          CLR_IR   = 1'b1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       fetch_req,
    input  logic       hold,
    output logic       busy,
    output logic       fetch_done,
    output logic       Mem_En,
    output logic [1:0] ARF_OutDSel,
    output logic [3:0] ARF_RegSel,
    output logic [1:0] ARF_FunSel,
    output logic       IR_En,
    output logic       IR_LH,
    output logic [1:0] IR_FunSel
);

    if (WAIT_CYC > 15) begin : g_wait_cyc_range
        $error("instr_fetch_seq: WAIT_CYC must be 0..15");
    end

    fetch_state_t state;
    fetch_state_t nxt;
    fetch_ctrl_t  ctrl;
    logic         in_addr;
    logic         wc_load;
    logic         wc_en;
    logic         wc_tc;

    assign in_addr = (state == F_LO_ADDR) || (state == F_HI_ADDR);
    assign wc_load = !hold && !in_addr;
    assign wc_en   = !hold && in_addr && !wc_tc;

    wait_counter #(
        .TC(4'(WAIT_CYC))
    ) u_wait (
        .CLK  (CLK),
        .RST_N(RST_N),
        .load (wc_load),
        .en   (wc_en),
        .tc   (wc_tc)
    );

    always_comb begin
        nxt = state;
        if (!hold) begin
            case (state)
                F_IDLE:    if (fetch_req) nxt = CLR_IR ? F_CLR : F_LO_ADDR;
                F_CLR:     nxt = F_LO_ADDR;
                F_LO_ADDR: if (wc_tc) nxt = F_LO_LOAD;
                F_LO_LOAD: nxt = F_HI_ADDR;
                F_HI_ADDR: if (wc_tc) nxt = F_HI_LOAD;
                F_HI_LOAD: nxt = F_DONE;
                F_DONE:    nxt = F_IDLE;
                default:   nxt = F_IDLE;
            endcase
        end
    end

    // Control word is registered from the next state so every output is a flop.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= F_IDLE;
            ctrl  <= '0;
        end else begin
            state <= nxt;
            ctrl  <= fetch_decode(nxt);
        end
    end

    // hold suppresses every side effect in the current cycle, including a
    // load state that is arriving together with hold.
    assign busy        = ctrl.busy;
    assign fetch_done  = ctrl.fetch_done && !hold;
    assign Mem_En      = ctrl.mem_en;
    assign ARF_OutDSel = ctrl.outd_sel;
    assign ARF_RegSel  = hold ? RS_NONE : ctrl.reg_sel;
    assign ARF_FunSel  = ctrl.arf_fun;
    assign IR_En       = ctrl.ir_en && !hold;
    assign IR_LH       = ctrl.ir_lh;
    assign IR_FunSel   = ctrl.ir_fun;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Bench for instr_fetch_seq: two instances (defaults, and WAIT_CYC=3/CLR_IR=0)
// driving a behavioural ARF/IR/memory environment.
module tb_instr_fetch_seq;

    logic            clk;
    logic            rst_n;
    logic [1:0]      req;
    logic [1:0]      hold;
    logic [1:0]      busy;
    logic [1:0]      done;
    logic [1:0]      mem_en;
    logic [1:0][1:0] outd;
    logic [1:0][3:0] regsel;
    logic [1:0][1:0] arf_fs;
    logic [1:0]      ir_en;
    logic [1:0]      ir_lh;
    logic [1:0][1:0] ir_fs;

    logic [7:0]       mem [256];
    logic [1:0][15:0] pc;
    logic [1:0][15:0] ir;
    logic [1:0][7:0]  rd;
    logic [1:0]       ld;
    logic [1:0][15:0] ld_pc;
    logic [1:0][15:0] ld_ir;
    int               incs [2];

    int checks = 0;
    int failures = 0;

    instr_fetch_seq u0 (
        .CLK(clk), .RST_N(rst_n), .fetch_req(req[0]), .hold(hold[0]),
        .busy(busy[0]), .fetch_done(done[0]), .Mem_En(mem_en[0]),
        .ARF_OutDSel(outd[0]), .ARF_RegSel(regsel[0]), .ARF_FunSel(arf_fs[0]),
        .IR_En(ir_en[0]), .IR_LH(ir_lh[0]), .IR_FunSel(ir_fs[0])
    );

    instr_fetch_seq #(.WAIT_CYC(3), .CLR_IR(1'b0)) u1 (
        .CLK(clk), .RST_N(rst_n), .fetch_req(req[1]), .hold(hold[1]),
        .busy(busy[1]), .fetch_done(done[1]), .Mem_En(mem_en[1]),
        .ARF_OutDSel(outd[1]), .ARF_RegSel(regsel[1]), .ARF_FunSel(arf_fs[1]),
        .IR_En(ir_en[1]), .IR_LH(ir_lh[1]), .IR_FunSel(ir_fs[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory only answers when enabled with PC on OutD.
    always_comb begin
        for (int i = 0; i < 2; i++)
            rd[i] = (mem_en[i] && outd[i] == 2'b00) ? mem[pc[i][7:0]] : 8'hEE;
    end

    // ARF PC and IR stand-ins; they are not reset by the sequencer's reset.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (ld[i]) begin
                pc[i]   <= ld_pc[i];
                ir[i]   <= ld_ir[i];
                incs[i] <= 0;
            end else begin
                if (ir_en[i]) begin
                    case (ir_fs[i])
                        2'b10: if (ir_lh[i]) ir[i][15:8] <= rd[i];
                               else          ir[i][7:0]  <= rd[i];
                        2'b11: ir[i] <= 16'h0000;
                        default: ;
                    endcase
                end
                if (regsel[i][3]) begin
                    case (arf_fs[i])
                        2'b01: begin pc[i] <= pc[i] + 16'd1; incs[i] <= incs[i] + 1; end
                        2'b00: pc[i] <= pc[i] - 16'd1;
                        default: ;
                    endcase
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h @%0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [14:0] outs(input int i);
        return {busy[i], done[i], mem_en[i], ir_en[i], ir_lh[i], ir_fs[i],
                regsel[i], arf_fs[i], outd[i]};
    endfunction

    function automatic logic [14:0] mk(input bit b, input bit d, input bit m, input bit e,
                                       input bit lh, input logic [1:0] irf,
                                       input logic [3:0] rs, input logic [1:0] af);
        return {b, d, m, e, lh, irf, rs, af, 2'b00};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int i, input logic [15:0] p, input logic [15:0] r);
        ld[i] = 1'b1; ld_pc[i] = p; ld_ir[i] = r;
        tick();
        ld[i] = 1'b0;
    endtask

    function automatic logic [15:0] word_at(input logic [15:0] a);
        logic [7:0] lo;
        logic [7:0] hi;
        lo = a[7:0];
        hi = lo + 8'd1;
        return {mem[hi], mem[lo]};
    endfunction

    typedef struct {
        bit          req;
        bit          hold;
        logic [14:0] exp;
    } vec_t;

    vec_t tbl [8];

    // Random-phase reference: a fetch accepted in an unheld IDLE cycle with
    // fetch_req high finishes on its L-th unheld cycle.
    bit          m_busy [2];
    int          m_cnt  [2];
    logic [15:0] m_pc0  [2];
    int          m_inc0 [2];
    int          lat    [2];

    initial begin
        int dc;
        int dn;
        int bad;
        int prev_d;
        int dq[$];

        lat[0] = 6;
        lat[1] = 11;
        tbl[0] = '{1, 0, mk(0, 0, 0, 0, 0, 2'd0, 4'h0, 2'd0)};
        tbl[1] = '{0, 0, mk(1, 0, 0, 1, 0, 2'd3, 4'h0, 2'd0)};
        tbl[2] = '{0, 0, mk(1, 0, 1, 0, 0, 2'd0, 4'h0, 2'd0)};
        tbl[3] = '{0, 0, mk(1, 0, 1, 1, 0, 2'd2, 4'h8, 2'd1)};
        tbl[4] = '{0, 0, mk(1, 0, 1, 0, 0, 2'd0, 4'h0, 2'd0)};
        tbl[5] = '{0, 0, mk(1, 0, 1, 1, 1, 2'd2, 4'h8, 2'd1)};
        tbl[6] = '{0, 0, mk(1, 1, 0, 0, 0, 2'd0, 4'h0, 2'd0)};
        tbl[7] = '{0, 0, mk(0, 0, 0, 0, 0, 2'd0, 4'h0, 2'd0)};

        for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
        rst_n = 1'b0; req = '0; hold = '0; ld = '0; ld_pc = '0; ld_ir = '0;
        #3;
        chk("reset_outs_u0", 32'(outs(0)), 32'd0);
        chk("reset_outs_u1", 32'(outs(1)), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Default configuration, cycle by cycle
        mem[8'h10] = 8'h34; mem[8'h11] = 8'h12;
        preload(0, 16'h0010, 16'h0000);
        for (int r = 0; r < 8; r++) begin
            req[0] = tbl[r].req; hold[0] = tbl[r].hold;
            @(negedge clk);
            chk($sformatf("table_row%0d", r), 32'(outs(0)), 32'(tbl[r].exp));
            tick();
        end
        chk("table_ir", 32'(ir[0]), 32'h1234);
        chk("table_pc", 32'(pc[0]), 32'h0012);

        // hold for 4 cycles starting in LO_LOAD
        preload(0, 16'h0010, 16'h0000);
        dc = -1; dn = 0; bad = 0;
        for (int c = 0; c < 16; c++) begin
            req[0] = (c == 0); hold[0] = (c >= 3 && c < 7);
            @(negedge clk);
            if (hold[0] && (ir_en[0] || regsel[0] != 4'h0)) bad++;
            if (done[0]) begin dc = c; dn++; end
            tick();
        end
        hold[0] = 1'b0;
        chk("hold_no_side_effect", 32'(bad), 32'd0);
        chk("hold_done_cycle", 32'(dc), 32'd10);
        chk("hold_done_count", 32'(dn), 32'd1);
        chk("hold_ir", 32'(ir[0]), 32'h1234);
        chk("hold_pc", 32'(pc[0]), 32'h0012);
        chk("hold_incs", 32'(incs[0]), 32'd2);

        // WAIT_CYC=3, no clear, IR preloaded with ones
        mem[8'h40] = 8'hAA; mem[8'h41] = 8'h55;
        preload(1, 16'h0040, 16'hFFFF);
        dc = -1; dn = 0;
        for (int c = 0; c < 16; c++) begin
            req[1] = (c == 0);
            @(negedge clk);
            if (done[1]) begin dc = c; dn++; end
            tick();
        end
        chk("wait3_done_cycle", 32'(dc), 32'd11);
        chk("wait3_done_count", 32'(dn), 32'd1);
        chk("wait3_ir", 32'(ir[1]), 32'h55AA);
        chk("wait3_pc", 32'(pc[1]), 32'h0042);
        chk("wait3_incs", 32'(incs[1]), 32'd2);

        // asynchronous reset during HI_ADDR
        mem[8'h20] = 8'h77; mem[8'h21] = 8'h88; mem[8'h22] = 8'h99;
        preload(1, 16'h0020, 16'hABCD);
        dn = 0;
        for (int c = 0; c < 7; c++) begin
            req[1] = (c == 0);
            @(negedge clk);
            if (done[1]) dn++;
            tick();
        end
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outs", 32'(outs(1)), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_mid_no_done", 32'(dn), 32'd0);
        chk("rst_mid_busy", 32'(busy[1]), 32'd0);
        chk("rst_mid_pc", 32'(pc[1]), 32'h0021);
        chk("rst_mid_ir", 32'(ir[1]), 32'hAB77);
        dc = -1;
        for (int c = 0; c < 14; c++) begin
            req[1] = (c == 0);
            @(negedge clk);
            if (done[1]) dc = c;
            tick();
        end
        chk("rst_refetch_done", 32'(dc), 32'd11);
        chk("rst_refetch_ir", 32'(ir[1]), 32'h9988);
        chk("rst_refetch_pc", 32'(pc[1]), 32'h0023);

        // fetch_req held high: back-to-back fetches
        preload(0, 16'h0030, 16'h0000);
        bad = 0; prev_d = 0;
        for (int c = 0; c < 24; c++) begin
            req[0] = (c < 20);
            @(negedge clk);
            if (done[0]) dq.push_back(c);
            if (done[0] && prev_d != 0) bad++;
            prev_d = done[0];
            tick();
        end
        req[0] = 1'b0;
        chk("b2b_count", 32'(dq.size()), 32'd3);
        if (dq.size() == 3) begin
            chk("b2b_done0", 32'(dq[0]), 32'd6);
            chk("b2b_done1", 32'(dq[1]), 32'd13);
            chk("b2b_done2", 32'(dq[2]), 32'd20);
        end
        chk("b2b_pulse_width", 32'(bad), 32'd0);
        chk("b2b_pc", 32'(pc[0]), 32'h0036);
        chk("b2b_ir", 32'(ir[0]), 32'(word_at(16'h0034)));

        // randomized request/hold traffic on both instances
        preload(0, 16'($urandom), 16'($urandom));
        preload(1, 16'($urandom), 16'($urandom));
        for (int i = 0; i < 2; i++) m_busy[i] = 1'b0;
        for (int n = 0; n < 800; n++) begin
            for (int i = 0; i < 2; i++) begin
                req[i]  = ($urandom_range(0, 3) != 0);
                hold[i] = ($urandom_range(0, 5) == 0);
            end
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (hold[i])
                    chk($sformatf("rnd_hold_gate%0d", i),
                        32'({ir_en[i], regsel[i], done[i]}), 32'd0);
                if (!m_busy[i]) begin
                    chk($sformatf("rnd_idle%0d", i), 32'({busy[i], done[i]}), 32'd0);
                    if (req[i] && !hold[i]) begin
                        m_busy[i] = 1'b1;
                        m_cnt[i]  = 0;
                        m_pc0[i]  = pc[i];
                        m_inc0[i] = incs[i];
                    end
                end else begin
                    if (!hold[i]) m_cnt[i]++;
                    chk($sformatf("rnd_busy_done%0d", i), 32'({busy[i], done[i]}),
                        32'({1'b1, (!hold[i] && m_cnt[i] == lat[i])}));
                    if (!hold[i] && m_cnt[i] == lat[i]) begin
                        chk($sformatf("rnd_ir%0d", i), 32'(ir[i]), 32'(word_at(m_pc0[i])));
                        chk($sformatf("rnd_pc%0d", i), 32'(pc[i]), 32'(m_pc0[i] + 16'd2));
                        chk($sformatf("rnd_incs%0d", i), 32'(incs[i] - m_inc0[i]), 32'd2);
                        m_busy[i] = 1'b0;
                    end
                end
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch_seq.md
Name: instr_fetch_seq

Overview:
- Byte-serial instruction-fetch sequencer: the writer side of the IR load interface.
- On a fetch request it reads two consecutive bytes from the byte-wide instruction memory at the address in PC. PC is presented on the ARF OutD port.
- It drives IR En/L'H/FunSel to load the low byte, then the high byte, and increments PC via ARF after each byte.
- It sits between the control unit (fetch_req/fetch_done) and the ARF/IR/memory control pins.

Parameters:
- WAIT_CYC, 0, extra memory wait cycles per byte after the address is presented (0..15).
- CLR_IR, 1, when 1, spend one cycle clearing IR before the low-byte load.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- fetch_req  input  1  level request; sampled only in IDLE.
- hold  input  1  stall; freezes the sequence while high.
- busy  output  1  high in every state except IDLE.
- fetch_done  output  1  one-cycle pulse when both bytes are in IR.
- Mem_En  output  1  memory read enable (Mem_WR is tied low outside this block).
- ARF_OutDSel  output  2  ARF OutD select; PC_SEL=2'b00 while Mem_En=1.
- ARF_RegSel  output  4  ARF register enables, one bit per register, active-high; bit3=PC.
- ARF_FunSel  output  2  ARF function.
- IR_En  output  1  IR write enable.
- IR_LH  output  1  0 = low byte, 1 = high byte.
- IR_FunSel  output  2  IR function.

Behaviour:
- FunSel encoding, fixed team-wide: 00 DEC, 01 INC, 10 LOAD, 11 CLEAR.
- Reset (RST_N=0, asynchronous):
  - state=IDLE, wait counter=0.
  - All outputs 0, including ARF_OutDSel=00, ARF_RegSel=0000, IR_FunSel=00.
  - Reset mid-sequence abandons the fetch. No partial fetch_done. PC keeps however many increments already happened.
- States: IDLE, CLR, LO_ADDR, LO_LOAD, HI_ADDR, HI_LOAD, DONE.
- IDLE:
  - Outputs idle as at reset.
  - fetch_req=1 at an edge -> CLR if CLR_IR=1, else LO_ADDR.
- CLR (1 cycle):
  - IR_En=1, IR_FunSel=CLEAR.
  - Next state LO_ADDR.
- LO_ADDR (1+WAIT_CYC cycles):
  - Mem_En=1, ARF_OutDSel=PC_SEL.
  - Wait counter loads 0 on entry and counts up; exit when counter==WAIT_CYC.
  - Next state LO_LOAD.
- LO_LOAD (1 cycle):
  - Mem_En=1, ARF_OutDSel=PC_SEL.
  - IR_En=1, IR_LH=0, IR_FunSel=LOAD.
  - ARF_RegSel=1000, ARF_FunSel=INC. PC increments on the same edge the IR captures, so the byte is read from the old PC.
  - Next state HI_ADDR.
- HI_ADDR / HI_LOAD:
  - Identical to LO_ADDR / LO_LOAD except IR_LH=1 in HI_LOAD.
  - HI_LOAD -> DONE.
- DONE (1 cycle):
  - fetch_done=1, busy=1.
  - Next state IDLE. fetch_req still high is re-sampled in IDLE, giving a minimum 1-cycle IDLE gap between fetches.
- Latency: fetch_done is high in cycle CLR_IR + 2*(2+WAIT_CYC) + 1 after the sampling edge. Defaults give 6.
- In every state except the LOAD states and CLR: IR_En=0, ARF_RegSel=0000, IR_FunSel=00, ARF_FunSel=00.
- hold=1:
  - State and wait counter keep their values.
  - IR_En, ARF_RegSel and fetch_done are forced to 0, so no IR/PC side effect and no lost or duplicated increment.
  - Mem_En and ARF_OutDSel keep their state values.
  - hold in IDLE blocks acceptance of fetch_req.
- Simultaneous hold and arrival of a LOAD state: the load is deferred to the first cycle with hold=0.
- fetch_req changes while busy: ignored.
- Wait counter is 4 bits. WAIT_CYC>15 is a parameter error, enforced by an elaboration check.

Decomposition:
- Shared package `cpu_pkg` holds:
  - FunSel constants FS_DEC, FS_INC, FS_LOAD, FS_CLEAR.
  - ARF register-select constants (RS_PC=4'b1000).
  - PC_SEL=2'b00.
  - The fetch state enum. The future control-unit FSM reuses it.
- One sub-module: `wait_counter` (4-bit, load/enable/terminal-count). The FSM and output decode stay in the top module.

Test Plan:
- Defaults: reset, fetch_req=1 for 1 cycle, memory returns 0x34 at PC=0x10 and 0x12 at 0x11 -> IR=0x1234, PC=0x12, fetch_done one pulse 6 cycles after the sampling edge, busy low one cycle later.
- WAIT_CYC=3, CLR_IR=0, IR preloaded 0xFFFF, bytes 0xAA/0x55 -> IR=0x55AA, fetch_done at cycle 11, exactly two PC INC enables observed.
- hold=1 for 4 cycles entered during LO_LOAD -> IR_En and ARF_RegSel stay 0 throughout; after release, one load. Final IR and PC same as the undisturbed run; done delayed by 4.
- RST_N pulsed low during HI_ADDR -> outputs zero immediately (asynchronous). No fetch_done. PC=start+1, IR high byte unchanged. A new fetch_req completes normally.
- fetch_req held high continuously -> back-to-back fetches separated by exactly one IDLE cycle, PC advances by 2 per fetch, fetch_done never wider than 1 cycle.
- fetch_req toggled while busy -> no effect on sequence or timing.
